// File: rtl/inst_encoder_pkg.sv
// Shared definitions for the instruction encoder.
//   - RV32I major-opcode constants (TYPE_*).
//   - fmt_e: 3-bit instruction-format selector.
//   - upper_uniform(): checks that bits [31:lsb] of a word are all equal,
//     i.e. the value is representable as a signed (lsb+1)-bit field.
package inst_encoder_pkg;

    localparam logic [6:0] TYPE_OP_IMM = 7'b0010011;
    localparam logic [6:0] TYPE_JALR   = 7'b1100111;
    localparam logic [6:0] TYPE_LOAD   = 7'b0000011;
    localparam logic [6:0] TYPE_STORE  = 7'b0100011;
    localparam logic [6:0] TYPE_BRANCH = 7'b1100011;
    localparam logic [6:0] TYPE_LUI    = 7'b0110111;
    localparam logic [6:0] TYPE_AUIPC  = 7'b0010111;
    localparam logic [6:0] TYPE_JAL    = 7'b1101111;
    localparam logic [6:0] TYPE_OP     = 7'b0110011;

    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_S   = 3'd1,
        FMT_B   = 3'd2,
        FMT_U   = 3'd3,
        FMT_J   = 3'd4,
        FMT_R   = 3'd5,
        FMT_BAD = 3'd7
    } fmt_e;

    // Arithmetic shift leaves 0 or all-ones exactly when bits [31:lsb] agree.
    function automatic logic upper_uniform(input logic [31:0] v, input int unsigned lsb);
        logic [31:0] s;
        s = 32'($signed(v) >>> lsb);
        return (s == 32'h0000_0000) || (s == 32'hFFFF_FFFF);
    endfunction

endpackage

// File: rtl/inst_enc_fifo.sv
// Generic DEPTH x W synchronous FIFO with valid/ready on both sides.
// Ports:
//   clk, rst_n                 clock, async active-low reset (empties FIFO)
//   push_valid/push_ready/push_data   write side; push_ready = !full
//   pop_valid/pop_ready/pop_data      read side; pop_valid = !empty
// Handshake: a transfer happens on a clock edge where valid & ready are
// both high; data is held stable while valid is high and ready is low.
// pop_data reads as zero while empty so the head is clean after reset.
module inst_enc_fifo #(
    parameter int DEPTH = 2,
    parameter int W     = 33
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_valid,
    output logic         push_ready,
    input  logic [W-1:0] push_data,
    output logic         pop_valid,
    input  logic         pop_ready,
    output logic [W-1:0] pop_data
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    logic          push_fire;
    logic          pop_fire;

    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);
    assign push_ready = !full;
    assign pop_valid  = !empty;
    assign push_fire  = push_valid && !full;
    assign pop_fire   = pop_ready && !empty;
    assign pop_data   = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_fire) wr_ptr <= wr_ptr + 1'b1;
            if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_fire, pop_fire})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/inst_encoder.sv
// RV32I instruction encoder: packs opcode, register, funct and immediate
// fields into an instruction word and flags unrepresentable immediates.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   in_valid_i/in_ready_o           request handshake (in_ready_o = !full)
//   opcode_i, rd_i, rs1_i, rs2_i,
//   funct3_i, funct7_i, imm_i       instruction fields, imm_i unshifted
//   out_valid_o/out_ready_i         result handshake from FIFO head
//   inst_o, err_o                   head word; inst_o is 0 when err_o
//   err_sticky_o                    any errored push since reset/clear
//   clr_i                           sync clear of err_sticky_o and cnt_o
//   cnt_o                           number of pushed words, wraps
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [6:0]       opcode_i,
    input  logic [4:0]       rd_i,
    input  logic [4:0]       rs1_i,
    input  logic [4:0]       rs2_i,
    input  logic [2:0]       funct3_i,
    input  logic [6:0]       funct7_i,
    input  logic [31:0]      imm_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [31:0]      inst_o,
    output logic             err_o,
    output logic             err_sticky_o,
    input  logic             clr_i,
    output logic [CNT_W-1:0] cnt_o
);
    fmt_e        fmt;
    logic [31:0] packed_inst;
    logic        range_ok;
    logic        enc_err;
    logic [31:0] enc_inst;
    logic        push_fire;

    always_comb begin
        case (opcode_i)
            TYPE_OP_IMM, TYPE_JALR, TYPE_LOAD: fmt = FMT_I;
            TYPE_STORE:                        fmt = FMT_S;
            TYPE_BRANCH:                       fmt = FMT_B;
            TYPE_LUI, TYPE_AUIPC:              fmt = FMT_U;
            TYPE_JAL:                          fmt = FMT_J;
            TYPE_OP:                           fmt = FMT_R;
            default:                           fmt = FMT_BAD;
        endcase
    end

    always_comb begin
        packed_inst = 32'h0000_0000;
        range_ok    = 1'b1;
        case (fmt)
            FMT_I: begin
                packed_inst = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
                range_ok    = upper_uniform(imm_i, 11);
            end
            FMT_S: begin
                packed_inst = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
                range_ok    = upper_uniform(imm_i, 11);
            end
            FMT_B: begin
                packed_inst = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                               imm_i[4:1], imm_i[11], opcode_i};
                range_ok    = upper_uniform(imm_i, 12) && !imm_i[0];
            end
            FMT_U: begin
                packed_inst = {imm_i[31:12], rd_i, opcode_i};
                range_ok    = (imm_i[11:0] == 12'h000);
            end
            FMT_J: begin
                packed_inst = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
                range_ok    = upper_uniform(imm_i, 20) && !imm_i[0];
            end
            FMT_R: begin
                packed_inst = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
            end
            default: range_ok = 1'b0;
        endcase
    end

    assign enc_err   = !range_ok;
    assign enc_inst  = enc_err ? 32'h0000_0000 : packed_inst;
    assign push_fire = in_valid_i && in_ready_o;

    inst_enc_fifo #(
        .DEPTH (DEPTH),
        .W     (33)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_valid (in_valid_i),
        .push_ready (in_ready_o),
        .push_data  ({enc_err, enc_inst}),
        .pop_valid  (out_valid_o),
        .pop_ready  (out_ready_i),
        .pop_data   ({err_o, inst_o})
    );

    // Clear wins over a same-cycle push for both the count and the sticky flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_o        <= '0;
            err_sticky_o <= 1'b0;
        end else if (clr_i) begin
            cnt_o        <= '0;
            err_sticky_o <= 1'b0;
        end else if (push_fire) begin
            cnt_o <= cnt_o + 1'b1;
            if (enc_err) err_sticky_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    localparam int DEPTH = 2;
    localparam int CNT_W = 16;

    logic             clk;
    logic             rst_n;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [6:0]       opcode_i;
    logic [4:0]       rd_i;
    logic [4:0]       rs1_i;
    logic [4:0]       rs2_i;
    logic [2:0]       funct3_i;
    logic [6:0]       funct7_i;
    logic [31:0]      imm_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [31:0]      inst_o;
    logic             err_o;
    logic             err_sticky_o;
    logic             clr_i;
    logic [CNT_W-1:0] cnt_o;

    int checks   = 0;
    int failures = 0;

    logic [32:0]      exp_q[$];
    logic [CNT_W-1:0] exp_cnt;

    inst_encoder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid_i   (in_valid_i),
        .in_ready_o   (in_ready_o),
        .opcode_i     (opcode_i),
        .rd_i         (rd_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .funct3_i     (funct3_i),
        .funct7_i     (funct7_i),
        .imm_i        (imm_i),
        .out_valid_o  (out_valid_o),
        .out_ready_i  (out_ready_i),
        .inst_o       (inst_o),
        .err_o        (err_o),
        .err_sticky_o (err_sticky_o),
        .clr_i        (clr_i),
        .cnt_o        (cnt_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: a transfer happens at the next posedge when valid & ready at negedge.
    always @(negedge clk) begin
        if (rst_n && out_valid_o && out_ready_i) begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_output actual=0x%0h expected=none", {err_o, inst_o});
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                if ({err_o, inst_o} !== e) begin
                    failures++;
                    $display("FAIL output_word actual err=%0b inst=0x%08h expected err=%0b inst=0x%08h",
                             err_o, inst_o, e[32], e[31:0]);
                end
            end
        end
    end

    // ---------------- driver ----------------
    // Drives a request and holds it until accepted; expected result queued at accept.
    task automatic push(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic [31:0] e_inst, input logic e_err);
        int waited;
        opcode_i   = op;
        rd_i       = rd;
        rs1_i      = rs1;
        rs2_i      = rs2;
        funct3_i   = f3;
        funct7_i   = f7;
        imm_i      = imm;
        in_valid_i = 1'b1;
        waited     = 0;
        forever begin
            @(negedge clk);
            if (in_ready_o) break;
            waited++;
            if (waited > 50) begin
                check("push_timeout", 64'(waited), 64'd0);
                break;
            end
            @(posedge clk);
            #1;
        end
        if (in_ready_o) begin
            exp_q.push_back({e_err, e_inst});
            exp_cnt = exp_cnt + 1'b1;
        end
        @(posedge clk);
        #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 100) begin
            @(posedge clk);
            waited++;
        end
        #1;
        check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst_n = 1'b0;
        in_valid_i = 1'b0; out_ready_i = 1'b1; clr_i = 1'b0;
        opcode_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        funct3_i = '0; funct7_i = '0; imm_i = '0;
        exp_cnt = '0;
        #12;
        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_in_ready", 64'(in_ready_o), 64'd1);
        check("reset_inst", 64'(inst_o), 64'd0);
        check("reset_err", 64'(err_o), 64'd0);
        check("reset_sticky", 64'(err_sticky_o), 64'd0);
        check("reset_cnt", 64'(cnt_o), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi x1,x0,5 -> head valid on the following cycle
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 1'b0);
        @(negedge clk);
        check("addi_latency_valid", 64'(out_valid_o), 64'd1);
        check("addi_cnt", 64'(cnt_o), 64'd1);
        @(posedge clk); #1;

        push(7'b0100011, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'd12, 32'h0051_2623, 1'b0); // sw x5,12(x2)
        push(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_00EF, 1'b0);  // jal x1,8
        push(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_50B7, 1'b0); // lui
        // add x3,x1,x2 ; sub via funct7 0100000 -> 0x402081B3 ; imm ignored
        push(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'b0100000, 32'hFFFF_FFFF, 32'h4020_81B3, 1'b0);
        // beq x1,x2,-4 -> 0xFE208EE3
        push(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0);
        // addi x1,x0,-2048 (lower I boundary) -> 0x80000093
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800, 32'h8000_0093, 1'b0);
        drain();
        check("sticky_clean", 64'(err_sticky_o), 64'd0);

        // lui with unaligned immediate -> error word
        push(7'b0110111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5001, 32'h0, 1'b1);
        drain();
        check("lui_bad_sticky", 64'(err_sticky_o), 64'd1);

        // three more errors: odd branch, addi 2048, unknown opcode
        push(7'b1100011, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd3, 32'h0, 1'b1);
        push(7'b0010011, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 32'h0, 1'b1);
        push(7'b1111111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1);
        drain();
        check("err_cnt_advance", 64'(cnt_o), 64'(exp_cnt));
        check("err_cnt_value", 64'(cnt_o), 64'd11);

        // clear together with an errored push: clear wins
        clr_i = 1'b1;
        push(7'b1111111, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0, 32'h0, 1'b1);
        clr_i = 1'b0;
        exp_cnt = '0;
        check("clr_sticky", 64'(err_sticky_o), 64'd0);
        check("clr_cnt", 64'(cnt_o), 64'd0);
        drain();

        // fill with consumer stalled
        out_ready_i = 1'b0;
        push(7'b0010011, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1, 32'h0010_0113, 1'b0);
        push(7'b0010011, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2, 32'h0020_0193, 1'b0);
        @(negedge clk);
        check("full_in_ready", 64'(in_ready_o), 64'd0);
        check("full_head_inst", 64'(inst_o), 64'h0010_0113);
        @(negedge clk);
        check("full_head_stable", 64'(inst_o), 64'h0010_0113);
        check("full_head_valid", 64'(out_valid_o), 64'd1);
        // release consumer while offering a third word: no push on the full cycle
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        opcode_i = 7'b0010011; rd_i = 5'd4; rs1_i = 5'd0; funct3_i = 3'd0; imm_i = 32'd3;
        in_valid_i = 1'b1;
        @(negedge clk);
        check("full_cycle_no_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk); #1;
        check("full_cycle_no_push", 64'(cnt_o), 64'(exp_cnt));
        push(7'b0010011, 5'd4, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3, 32'h0030_0213, 1'b0);
        check("resume_cnt", 64'(cnt_o), 64'd3);
        drain();

        // async reset with two words queued
        out_ready_i = 1'b0;
        push(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd7, 32'h0070_0293, 1'b0);
        push(7'b0010011, 5'd6, 5'd0, 5'd0, 3'd0, 7'd0, 32'd8, 32'h0080_0313, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", 64'(out_valid_o), 64'd0);
        check("async_rst_cnt", 64'(cnt_o), 64'd0);
        check("async_rst_ready", 64'(in_ready_o), 64'd1);
        exp_q.delete();
        exp_cnt = '0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready_i = 1'b1;
        @(posedge clk); #1;
        push(7'b0010011, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'd9, 32'h0090_0393, 1'b0);
        @(negedge clk);
        check("post_rst_head", 64'(inst_o), 64'h0090_0393);
        drain();
        check("post_rst_cnt", 64'(cnt_o), 64'd1);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
